// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester ports A/B plus the SRAM pin bundle of the arbiter
interface sram_arbiter_if #(parameter int ADR = 15, parameter int DAT = 8);
  logic           a_req, a_we, a_ack;
  logic           b_req, b_we, b_ack;
  logic [ADR-1:0] a_addr, b_addr, mem_a;
  logic [DAT-1:0] a_wdata, a_rdata, b_wdata, b_rdata;
  logic [DAT-1:0] mem_din, mem_dout;
  logic           mem_ce_n, mem_we_n, mem_oe_n, busy;
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_dout,
    output a_rdata, a_ack, b_rdata, b_ack, mem_a, mem_din, mem_ce_n, mem_we_n, mem_oe_n, busy
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_dout,
    input  a_rdata, a_ack, b_rdata, b_ack, mem_a, mem_din, mem_ce_n, mem_we_n, mem_oe_n, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-port arbiter sequencing ce_n/we_n/oe_n cycles on one SRAM
module sram_arbiter #(parameter int ADR = 15, parameter int DAT = 8) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE, ACK} state_t;
  state_t         state_q, state_d;
  logic           last_b_q, last_b_d, gnt_b_q, gnt_b_d, wr_q, wr_d;
  logic           ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic           a_ack_q, a_ack_d, b_ack_q, b_ack_d, busy_q, busy_d;
  logic [ADR-1:0] mem_a_q, mem_a_d;
  logic [DAT-1:0] mem_din_q, mem_din_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic           pick_b;
  assign pick_b = bus.b_req && (!bus.a_req || !last_b_q);
  // next state: grant in IDLE, strobe for one cycle, then capture read data and pulse ack
  always_comb begin
    state_d   = state_q;
    last_b_d  = last_b_q;
    gnt_b_d   = gnt_b_q;
    wr_d      = wr_q;
    ce_n_d    = ce_n_q;
    we_n_d    = we_n_q;
    oe_n_d    = oe_n_q;
    a_ack_d   = a_ack_q;
    b_ack_d   = b_ack_q;
    mem_a_d   = mem_a_q;
    mem_din_d = mem_din_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      IDLE: if (bus.a_req || bus.b_req) begin
        gnt_b_d   = pick_b;
        last_b_d  = pick_b;
        wr_d      = pick_b ? bus.b_we : bus.a_we;
        mem_a_d   = pick_b ? bus.b_addr : bus.a_addr;
        mem_din_d = pick_b ? bus.b_wdata : bus.a_wdata;
        ce_n_d    = 1'b0;
        we_n_d    = !wr_d;
        oe_n_d    = wr_d;
        state_d   = ACCESS;
      end
      ACCESS: begin
        ce_n_d  = 1'b1;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        state_d = COMPLETE;
      end
      COMPLETE: begin
        a_ack_d   = !gnt_b_q;
        b_ack_d   = gnt_b_q;
        a_rdata_d = (!wr_q && !gnt_b_q) ? bus.mem_dout : a_rdata_q;
        b_rdata_d = (!wr_q && gnt_b_q) ? bus.mem_dout : b_rdata_q;
        state_d   = ACK;
      end
      default: begin
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  // all state and outputs registered; reset leaves last grant on B so A wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b1;
      gnt_b_q   <= 1'b0;
      wr_q      <= 1'b0;
      ce_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
      mem_a_q   <= '0;
      mem_din_q <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      gnt_b_q   <= gnt_b_d;
      wr_q      <= wr_d;
      ce_n_q    <= ce_n_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      busy_q    <= busy_d;
      mem_a_q   <= mem_a_d;
      mem_din_q <= mem_din_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_ce_n = ce_n_q;
  assign bus.mem_we_n = we_n_q;
  assign bus.mem_oe_n = oe_n_q;
  assign bus.a_ack    = a_ack_q;
  assign bus.b_ack    = b_ack_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized requesters against a transaction-timeline reference model
module tb_sram_arbiter;
  typedef struct packed {logic we; logic [14:0] addr; logic [7:0] wd;} txn_t;
  logic clk = 0, rst = 0, hold = 0, tmo = 0;
  logic req[2], we[2];
  logic [14:0] addr[2];
  logic [7:0] wd[2];
  logic [7:0] sram[32768], ref_mem[32768], sram_dout = 0;
  logic s_loaded = 0, m_loaded = 0;
  txn_t qa[$], qb[$];
  int n_chk = 0, n_err = 0;
  int e = 0, g_e = 0, g_wait = 0, wstart[2];
  logic act = 0, last_b = 1, m_port = 0, m_wr = 0, waiting[2];
  logic [14:0] m_addr = 0;
  logic [7:0] m_wd = 0, m_rd = 0, exp_rd[2];
  sram_arbiter_if bus();
  sram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.a_req = req[0];
  assign bus.a_we = we[0];
  assign bus.a_addr = addr[0];
  assign bus.a_wdata = wd[0];
  assign bus.b_req = req[1];
  assign bus.b_we = we[1];
  assign bus.b_addr = addr[1];
  assign bus.b_wdata = wd[1];
  assign bus.mem_dout = sram_dout;
  function automatic logic [7:0] init_val(input int i);
    return (i == 32'h123) ? 8'h5A : 8'((i * 7) ^ (i >> 3));
  endfunction
  function automatic txn_t rnd_txn();
    txn_t t;
    t.we = 1'($urandom % 2);
    t.addr = (($urandom % 2) != 0 ? 15'h7FF0 : 15'h0) | 15'($urandom % 16);
    t.wd = 8'($urandom);
    return t;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // synchronous SRAM: write/read on an edge with ce_n low, read data valid the following cycle
  always @(posedge clk) begin
    if (rst && !s_loaded) begin
      for (int i = 0; i < 32768; i++) sram[i] = init_val(i);
      s_loaded = 1;
    end else if (!bus.mem_ce_n) begin
      if (!bus.mem_we_n) sram[bus.mem_a] = bus.mem_din;
      if (!bus.mem_oe_n) sram_dout = sram[bus.mem_a];
    end
  end
  // reference model: each transaction occupies edges g..g+3, grant chosen round-robin on ties
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if (!m_loaded) begin
        for (int i = 0; i < 32768; i++) ref_mem[i] = init_val(i);
        m_loaded = 1;
      end
      act = 0;
      last_b = 1;
      e = 0;
      exp_rd[0] = 0;
      exp_rd[1] = 0;
      waiting[0] = 0;
      waiting[1] = 0;
    end else begin
      e++;
      for (int p = 0; p < 2; p++)
        if (req[p] && !waiting[p] && !(act && m_port == 1'(p))) begin
          waiting[p] = 1;
          wstart[p] = e;
        end
      if (act) begin
        if (e - g_e == 2) begin
          if (m_wr) ref_mem[m_addr] = m_wd;
          else exp_rd[m_port] = m_rd;
        end
        if (e - g_e == 3) act = 0;
      end else if (req[0] || req[1]) begin
        m_port = (req[0] && req[1]) ? !last_b : req[1];
        last_b = m_port;
        act = 1;
        g_e = e;
        m_wr = we[m_port];
        m_addr = addr[m_port];
        m_wd = wd[m_port];
        m_rd = ref_mem[m_addr];
        g_wait = e - wstart[m_port];
        waiting[m_port] = 0;
      end
    end
  end
  // all comparisons: reset state right after rst rises, full output set every falling edge
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      #1;
      check("rst_strobes", {bus.mem_ce_n, bus.mem_we_n, bus.mem_oe_n}, 3'b111);
      check("rst_busy", bus.busy, 0);
      check("rst_acks", {bus.a_ack, bus.b_ack}, 0);
      check("rst_mem_a", bus.mem_a, 0);
      check("rst_mem_din", bus.mem_din, 0);
      check("rst_rdata", {bus.a_rdata, bus.b_rdata}, 0);
    end else begin
      int d;
      d = e - g_e;
      check("we_oe_excl", !(!bus.mem_we_n && !bus.mem_oe_n), 1);
      check("strobe_busy", (bus.mem_ce_n && bus.mem_we_n && bus.mem_oe_n) || bus.busy, 1);
      check("timeout", tmo, 0);
      check("strobes", {bus.mem_ce_n, bus.mem_we_n, bus.mem_oe_n},
            (act && d == 0) ? {1'b0, !m_wr, m_wr} : 3'b111);
      if (act && d <= 1) begin
        check("mem_a", bus.mem_a, m_addr);
        if (m_wr) check("mem_din", bus.mem_din, m_wd);
      end
      if (act && d == 0) check("fair_wait", g_wait <= 8, 1);
      check("busy", bus.busy, act && d < 3);
      check("a_ack", bus.a_ack, act && d == 2 && !m_port);
      check("b_ack", bus.b_ack, act && d == 2 && m_port);
      check("a_rdata", bus.a_rdata, exp_rd[0]);
      check("b_rdata", bus.b_rdata, exp_rd[1]);
    end
  end
  // one cycle of requester behaviour: drop req on ack, raise the next queued transaction
  task automatic cyc();
    txn_t t;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      if (req[p] && (p == 1 ? bus.b_ack : bus.a_ack)) req[p] = 0;
      else if (!req[p] && (p == 1 ? qb.size() : qa.size()) > 0 && (hold || $urandom % 3 == 0)) begin
        if (p == 1) t = qb.pop_front();
        else t = qa.pop_front();
        we[p] = t.we;
        addr[p] = t.addr;
        wd[p] = t.wd;
        req[p] = 1;
      end
    end
  endtask
  task automatic run_idle();
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || req[0] || req[1]) && n < 3000) begin
      cyc();
      n++;
    end
    if (n >= 3000) tmo = 1;
    repeat (4) cyc();
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (3) cyc();
    rst = 0;
  endtask
  initial begin
    for (int p = 0; p < 2; p++) begin
      req[p] = 0;
      we[p] = 0;
      addr[p] = 0;
      wd[p] = 0;
    end
    #1 rst = 1;
    repeat (3) cyc();
    rst = 0;
    qa.push_back('{1'b0, 15'h0123, 8'h00});
    run_idle();
    qb.push_back('{1'b1, 15'h7FFF, 8'hC3});
    qb.push_back('{1'b0, 15'h7FFF, 8'h00});
    run_idle();
    do_reset();
    hold = 1;
    qa.push_back(rnd_txn());
    qb.push_back(rnd_txn());
    run_idle();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(rnd_txn());
      qb.push_back(rnd_txn());
    end
    run_idle();
    hold = 0;
    qb.push_back('{1'b1, 15'h0042, 8'h99});
    begin
      int n = 0;
      do begin
        cyc();
        n++;
      end while (bus.mem_we_n && n < 40);
      if (n >= 40) tmo = 1;
    end
    #2 rst = 1;
    #1 rst = 0;
    run_idle();
    qa.push_back('{1'b0, 15'h0042, 8'h00});
    run_idle();
    for (int i = 0; i < 60; i++) begin
      qa.push_back(rnd_txn());
      qb.push_back(rnd_txn());
    end
    run_idle();
    hold = 1;
    for (int i = 0; i < 20; i++) begin
      qa.push_back(rnd_txn());
      qb.push_back(rnd_txn());
    end
    run_idle();
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
